// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift-path types and constants for the ALU shifter and normalizer
// Contents:
//   norm_state_t   : lead_normalizer FSM states
//   SLL/SRL/SRA    : ALU shift opcodes shared with the barrel shifter
//   NORM_*         : normalizer mode encoding carried on in_signed
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } norm_state_t;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

endpackage

// File: rtl/lead_step_detect.sv
// rtl/lead_step_detect.sv - decides whether the normalizer may take a coarse or a fine left shift
// Ports:
//   work      in  m  current partially normalized operand
//   mode      in  1  NORM_UNSIGNED / NORM_SIGNED
//   coarse_ok out 1  a STEP-bit shift keeps the value normalizable
//   fine_ok   out 1  a 1-bit shift keeps the value normalizable
module lead_step_detect
    import shift_pkg::*;
#(
    parameter int m    = 32,
    parameter int STEP = 4
) (
    input  logic [m-1:0] work,
    input  logic         mode,
    output logic         coarse_ok,
    output logic         fine_ok
);

    logic [STEP-1:0] top_u;
    logic [STEP:0]   top_s;

    assign top_u = work[m-1 -: STEP];
    // Signed needs one extra bit: the sign bit that must survive the shift.
    assign top_s = work[m-1 -: STEP+1];

    always_comb begin
        coarse_ok = 1'b0;
        fine_ok   = 1'b0;
        if (mode == NORM_SIGNED) begin
            coarse_ok = (top_s == '0) || (top_s == '1);
            fine_ok   = (work[m-1] == work[m-2]);
        end else begin
            coarse_ok = (top_u == '0);
            fine_ok   = ~work[m-1];
        end
    end

endmodule

// File: rtl/lead_normalizer.sv
// rtl/lead_normalizer.sv - multi-cycle CLZ/CLS normalizer with valid/ready handshakes
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_data operand, in_signed mode
//   out_valid/out_ready   result handshake
//   out_data              operand shifted left by out_count
//   out_count             left-shift amount applied (m for an unsigned zero)
//   out_zero              operand was exactly zero
module lead_normalizer
    import shift_pkg::*;
#(
    parameter int m    = 32,
    parameter int STEP = 4,
    parameter int CW   = $clog2(m) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [m-1:0]  in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [m-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_zero
);

    norm_state_t   state, next_state;
    logic [m-1:0]  work;
    logic [m-1:0]  orig;
    logic [CW-1:0] count;
    logic          mode;
    logic          zero;
    logic          coarse_ok, fine_ok;
    logic          accept;
    logic          in_all_zero, in_all_ones;
    logic          special;

    lead_step_detect #(.m(m), .STEP(STEP)) u_detect (
        .work      (work),
        .mode      (mode),
        .coarse_ok (coarse_ok),
        .fine_ok   (fine_ok)
    );

    assign in_all_zero = (in_data == '0);
    assign in_all_ones = (in_data == '1);
    // Operands whose answer is known without scanning finish on the acceptance edge.
    assign special = (in_signed == NORM_SIGNED) ? (in_all_zero | in_all_ones) : in_all_zero;
    assign accept  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = special ? DONE : SCAN;
            end
            SCAN: begin
                if (!coarse_ok && !fine_ok) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            orig  <= '0;
            count <= '0;
            mode  <= NORM_UNSIGNED;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        orig <= in_data;
                        mode <= in_signed;
                        if (in_signed == NORM_UNSIGNED && in_all_zero) begin
                            work  <= '0;
                            count <= CW'(m);
                            zero  <= 1'b1;
                        end else if (in_signed == NORM_SIGNED && special) begin
                            work  <= in_data << (m - 1);
                            count <= CW'(m - 1);
                            zero  <= in_all_zero;
                        end else begin
                            work  <= in_data;
                            count <= '0;
                            zero  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (coarse_ok) begin
                        work  <= work << STEP;
                        count <= count + CW'(STEP);
                    end else if (fine_ok) begin
                        work  <= work << 1;
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = work;
    assign out_count = count;
    assign out_zero  = zero;

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            assert (!$isunknown(in_signed))
                else $error("in_signed unknown at acceptance");
        end
        if (rst_n && out_valid) begin
            assert (out_data == (orig << out_count))
                else $error("out_data is not orig << out_count");
            if (mode == NORM_UNSIGNED && !zero) begin
                assert (out_data[m-1])
                    else $error("unsigned result not normalized");
            end
            if (mode == NORM_SIGNED && out_count != CW'(m - 1)) begin
                assert (out_data[m-1] != out_data[m-2])
                    else $error("signed result not normalized");
            end
        end
    end

endmodule
